// File: rtl/sequence_generator_if.sv
// rtl/sequence_generator_if.sv - handshake/bus bundle for the code sequence generator
//
// Purpose: groups the request, configuration and result signals of
// sequence_generator so the generator and its user connect through one port.
// Ports (signals):
//   start      requester -> generator  asynchronous generation request (rising edge)
//   count      requester -> generator  number of slots to fill
//   no_repeat  requester -> generator  reject a code equal to the previous slot
//   abort      requester -> generator  synchronous abort back to idle
//   seed_load  requester -> generator  load seed into the LFSR
//   seed       requester -> generator  seed value
//   codes      generator -> requester  packed slot codes, slot i at [i*CODE_W +: CODE_W]
//   busy       generator -> requester  generation in progress
//   valid      generator -> requester  finished sequence held
//   done       generator -> requester  one-cycle pulse when the sequence completes
interface sequence_generator_if #(
    parameter int NUM_SLOTS = 16,
    parameter int CODE_W    = 4,
    parameter int COUNT_W   = $clog2(NUM_SLOTS + 1),
    parameter int LFSR_W    = 16
);
    logic                        start;
    logic [COUNT_W-1:0]          count;
    logic                        no_repeat;
    logic                        abort;
    logic                        seed_load;
    logic [LFSR_W-1:0]           seed;
    logic [NUM_SLOTS*CODE_W-1:0] codes;
    logic                        busy;
    logic                        valid;
    logic                        done;

    modport master (
        output start, count, no_repeat, abort, seed_load, seed,
        input  codes, busy, valid, done
    );

    modport slave (
        input  start, count, no_repeat, abort, seed_load, seed,
        output codes, busy, valid, done
    );
endinterface

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - seedable LFSR driven multi-slot code sequence generator
//
// Purpose: on a rising edge of the (asynchronous) start request, fills up to
// NUM_SLOTS code slots with pseudo-random codes, one per accepted cycle, then
// holds the sequence until restarted or aborted. All-ones marks an empty slot.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   sequence_generator_if.slave (start/count/no_repeat/abort/seed_load/seed
//         in; codes/busy/valid/done out)
module sequence_generator #(
    parameter int                NUM_SLOTS = 16,
    parameter int                CODE_W    = 4,
    parameter int                COUNT_W   = $clog2(NUM_SLOTS + 1),
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    sequence_generator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [LFSR_W-1:0]  TAPS    = LFSR_W'(16'hB400);
    localparam logic [CODE_W-1:0]  EMPTY   = '1;
    localparam logic [COUNT_W-1:0] MAX_TGT = COUNT_W'(NUM_SLOTS);

    state_t                      state_q, state_d;
    logic                        start_meta, start_sync, start_prev, start_edge;
    logic [LFSR_W-1:0]           lfsr_q, lfsr_adv;
    logic [NUM_SLOTS*CODE_W-1:0] codes_q;
    logic [COUNT_W-1:0]          index_q, target_q, count_clamped;
    logic                        nr_q, done_q, done_d;
    logic                        accept, clear, latch, reject;
    logic [CODE_W-1:0]           candidate, prev_code;

    assign count_clamped = (bus.count > MAX_TGT) ? MAX_TGT : bus.count;
    assign candidate     = lfsr_q[CODE_W-1:0];
    assign lfsr_adv      = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    // Code of the slot written just before index_q (only meaningful for index_q > 0).
    always_comb begin
        prev_code = EMPTY;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            if (int'(index_q) == i) begin
                prev_code = codes_q[(i-1)*CODE_W +: CODE_W];
            end
        end
    end

    assign reject = (candidate == EMPTY) ||
                    (nr_q && (index_q != '0) && (candidate == prev_code));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        clear   = 1'b0;
        latch   = 1'b0;
        done_d  = 1'b0;
        if (bus.abort) begin
            // Abort wins over any start edge seen in the same cycle.
            state_d = IDLE;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (start_edge) begin
                        latch = 1'b1;
                        clear = 1'b1;
                        if (count_clamped == '0) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GEN;
                        end
                    end
                end
                GEN: begin
                    // start edges are deliberately ignored while generating.
                    if ((index_q < target_q) && !reject) begin
                        accept = 1'b1;
                        if (COUNT_W'(index_q + 1'b1) == target_q) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            start_edge <= 1'b0;
            lfsr_q     <= SEED;
            codes_q    <= '1;
            index_q    <= '0;
            target_q   <= '0;
            nr_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Two synchroniser flops, then a registered edge pulse: a start
            // rise sampled at edge k shows up as start_edge after edge k+2.
            start_meta <= bus.start;
            start_sync <= start_meta;
            start_prev <= start_sync;
            start_edge <= start_sync & ~start_prev;

            // Reseeding mid-generation would corrupt a sequence in flight.
            if (bus.seed_load && (state_q != GEN)) begin
                lfsr_q <= (bus.seed == '0) ? SEED : bus.seed;
            end else begin
                lfsr_q <= lfsr_adv;
            end

            if (latch) begin
                target_q <= count_clamped;
                nr_q     <= bus.no_repeat;
                index_q  <= '0;
            end else if (accept) begin
                index_q  <= index_q + 1'b1;
            end

            if (clear) begin
                codes_q <= '1;
            end else if (accept) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (int'(index_q) == i) begin
                        codes_q[i*CODE_W +: CODE_W] <= candidate;
                    end
                end
            end

            done_q <= done_d;
        end
    end

    assign bus.codes = codes_q;
    assign bus.busy  = (state_q == GEN);
    assign bus.valid = (state_q == HOLD);
    assign bus.done  = done_q;
endmodule
